// File: rtl/generate2_stim_pkg.sv
// rtl/generate2_stim_pkg.sv - shared types and helpers for the generate2 operand sequencer
package generate2_stim_pkg;

    typedef enum logic [1:0] {
        MODE_SWEEP = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            default: return 32'h8020_0003;
        endcase
    endfunction

    // Rotate the low `width` bits of value left; bits above width come back as zero.
    function automatic logic [31:0] rotl(input logic [31:0] value, input int amount, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[5'((i + amount) % width)] = value[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/generate2_stim_lfsr.sv
// rtl/generate2_stim_lfsr.sv - Galois right-shift LFSR with load and step enable
module generate2_stim_lfsr
    import generate2_stim_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] state_q, state_d;

    // An all-zero state would lock up, so a zero seed becomes 1.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_value == '0) ? WIDTH'(1) : load_value;
        end else if (enable) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/generate2_stim_seq.sv
// rtl/generate2_stim_seq.sv - programmable-length (a, b) operand stream generator for generate2
module generate2_stim_seq
    import generate2_stim_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] issued
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [WIDTH-1:0] sweep_q, sweep_d;
    logic [WIDTH-1:0] walk_q, walk_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             lfsr_load, lfsr_en;
    logic [WIDTH-1:0] lfsr_state;

    generate2_stim_lfsr #(.WIDTH(WIDTH)) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (lfsr_load),
        .load_value (seed),
        .enable     (lfsr_en),
        .state      (lfsr_state)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        count_d   = count_q;
        issued_d  = issued_q;
        sweep_d   = sweep_q;
        walk_d    = walk_q;
        a_d       = a_q;
        b_d       = b_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mode_d    = mode_e'(mode);
                    count_d   = count;
                    issued_d  = '0;
                    sweep_d   = '0;
                    walk_d    = WIDTH'(1);
                    lfsr_load = 1'b1;
                    case (mode_e'(mode))
                        MODE_SWEEP: begin a_d = '0;        b_d = '1;        end
                        MODE_WALK:  begin a_d = WIDTH'(1); b_d = WIDTH'(2); end
                        default:    begin a_d = seed;      b_d = ~seed;     end
                    endcase
                    state_d = (count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    issued_d = issued_q + 1'b1;
                    lfsr_en  = 1'b1;
                    if (issued_d == count_q) begin
                        state_d = DONE;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                        walk_d  = WIDTH'(rotl(32'(walk_q), 1, WIDTH));
                        case (mode_q)
                            MODE_SWEEP: begin a_d = sweep_d; b_d = ~sweep_d; end
                            MODE_WALK:  begin
                                a_d = walk_d;
                                b_d = WIDTH'(rotl(32'(walk_d), 1, WIDTH));
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            mode_q   <= MODE_SWEEP;
            count_q  <= '0;
            issued_q <= '0;
            sweep_q  <= '0;
            walk_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            sweep_q  <= sweep_d;
            walk_q   <= walk_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    // LFSR beats come straight from the generator state; other modes use the a/b registers.
    assign a         = (mode_q == MODE_LFSR) ? lfsr_state : a_q;
    assign b         = (mode_q == MODE_LFSR) ? WIDTH'(rotl(32'(lfsr_state), WIDTH / 2, WIDTH)) : b_q;
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign issued    = issued_q;

endmodule

// File: tb/tb_generate2_stim_seq.sv
// tb/tb_generate2_stim_seq.sv - self-checking bench for generate2_stim_seq
module tb_generate2_stim_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] count;
    logic [7:0]  seed;
    logic [7:0]  a, b;
    logic        out_valid, out_ready, busy, done;
    logic [15:0] issued;

    int checks   = 0;
    int failures = 0;

    generate2_stim_seq #(.WIDTH(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .count     (count),
        .seed      (seed),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .issued    (issued)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  mode;
        logic [7:0]  seed;
        logic [15:0] count;
        logic [31:0] ea;
        logic [31:0] eb;
    } run_t;

    run_t runs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic [7:0] s, input logic [15:0] c);
        mode  = m;
        seed  = s;
        count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(output int n);
        n = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (done) break;
            if (out_valid && out_ready) n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int k;
        logic [7:0] ea, eb;

        runs[0] = '{mode: 2'd0, seed: 8'h00, count: 16'd4, ea: 32'h03020100, eb: 32'hFCFDFEFF};
        runs[1] = '{mode: 2'd1, seed: 8'h01, count: 16'd3, ea: 32'h005CB801, eb: 32'h00C58B10};
        runs[2] = '{mode: 2'd1, seed: 8'h00, count: 16'd3, ea: 32'h005CB801, eb: 32'h00C58B10};
        runs[3] = '{mode: 2'd2, seed: 8'h00, count: 16'd4, ea: 32'h08040201, eb: 32'h10080402};
        runs[4] = '{mode: 2'd3, seed: 8'h5A, count: 16'd2, ea: 32'h00005A5A, eb: 32'h0000A5A5};
        runs[5] = '{mode: 2'd0, seed: 8'h77, count: 16'd1, ea: 32'h00000000, eb: 32'h000000FF};

        rst = 1'b0; start = 1'b0; mode = 2'd0; count = 16'd0; seed = 8'h00; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_issued", 32'(issued), 32'd0);
        rst = 1'b1;
        tick();

        for (int r = 0; r < 6; r++) begin
            do_start(runs[r].mode, runs[r].seed, runs[r].count);
            out_ready = 1'b1;
            for (int i = 0; i < int'(runs[r].count); i++) begin
                chk($sformatf("run%0d_valid%0d", r, i), 32'(out_valid), 32'd1);
                chk($sformatf("run%0d_a%0d", r, i), 32'(a), 32'(runs[r].ea[i*8 +: 8]));
                chk($sformatf("run%0d_b%0d", r, i), 32'(b), 32'(runs[r].eb[i*8 +: 8]));
                tick();
            end
            chk($sformatf("run%0d_done", r), 32'(done), 32'd1);
            chk($sformatf("run%0d_valid_end", r), 32'(out_valid), 32'd0);
            chk($sformatf("run%0d_issued", r), 32'(issued), 32'(runs[r].count));
        end

        // Walking-one with backpressure; beat 8 wraps back to bit 0.
        out_ready = 1'b0;
        do_start(2'd2, 8'h00, 16'd9);
        k = 0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            out_ready = (cyc % 3 == 0);
            ea = 8'd1 << (k % 8);
            eb = {ea[6:0], ea[7]};
            chk($sformatf("bp_valid_c%0d", cyc), 32'(out_valid), 32'd1);
            chk($sformatf("bp_a_c%0d", cyc), 32'(a), 32'(ea));
            chk($sformatf("bp_b_c%0d", cyc), 32'(b), 32'(eb));
            if (out_ready && out_valid) k++;
            tick();
        end
        chk("bp_transfers", 32'(k), 32'd9);
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_issued", 32'(issued), 32'd9);

        // Zero-length run.
        out_ready = 1'b1;
        do_start(2'd0, 8'h00, 16'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_valid", 32'(out_valid), 32'd0);
        chk("zero_issued", 32'(issued), 32'd0);
        tick();
        chk("zero_valid2", 32'(out_valid), 32'd0);

        // Reset mid-run, then a clean restart.
        do_start(2'd3, 8'h5A, 16'd10);
        tick(); tick(); tick();
        chk("mid_issued3", 32'(issued), 32'd3);
        rst = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_a", 32'(a), 32'd0);
        chk("mid_rst_b", 32'(b), 32'd0);
        chk("mid_rst_issued", 32'(issued), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("mid_idle_valid", 32'(out_valid), 32'd0);
        do_start(2'd3, 8'h5A, 16'd10);
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_a", 32'(a), 32'h5A);
        chk("restart_b", 32'(b), 32'hA5);
        run_until_done(n);
        chk("restart_xfers", 32'(n), 32'd10);
        chk("restart_issued", 32'(issued), 32'd10);

        // start during RUN is ignored.
        do_start(2'd0, 8'h00, 16'd5);
        out_ready = 1'b1;
        tick();
        start = 1'b1;
        count = 16'd2;
        tick();
        start = 1'b0;
        count = 16'd7;
        run_until_done(n);
        chk("ign_xfers_after", 32'(n), 32'd3);
        chk("ign_issued", 32'(issued), 32'd5);
        chk("ign_done", 32'(done), 32'd1);

        // Last-beat transfer wins over a coincident start.
        out_ready = 1'b0;
        do_start(2'd3, 8'h33, 16'd1);
        chk("last_valid", 32'(out_valid), 32'd1);
        start = 1'b1;
        count = 16'd3;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("last_done", 32'(done), 32'd1);
        chk("last_valid_end", 32'(out_valid), 32'd0);
        chk("last_issued", 32'(issued), 32'd1);
        tick();
        chk("last_hold_done", 32'(done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/generate2_stim_seq.md
Name: generate2_stim_seq

Overview:
- Upstream operand sequencer for generate2. Produces a programmable-length stream of (a, b) operand pairs over a valid/ready handshake.
- Supports four pattern modes: sweep, LFSR, walking-one and constant.
- Sits between the test/control logic and the generate2 input port. One beat is issued per accepted transfer.

Parameters:
- WIDTH, 8, operand width of a and b; legal values 8, 16, 32.
- CNT_W, 16, width of the beat-count field and of the issued counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous active-low reset: rst==0 at a rising clk edge resets the block.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- mode  in  2  pattern: 0 sweep, 1 LFSR, 2 walking-one, 3 constant; latched at start.
- count  in  CNT_W  number of beats in the run; latched at start.
- seed  in  WIDTH  LFSR seed / constant value; latched at start.
- a  out  WIDTH  operand a to generate2.
- b  out  WIDTH  operand b to generate2.
- out_valid  out  1  a/b hold a valid beat.
- out_ready  in  1  consumer accepts the beat.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- issued  out  CNT_W  beats accepted in the current or last run.

Behaviour:
- Reset (rst==0 at the edge): state IDLE; a=0, b=0, out_valid=0, busy=0, done=0, issued=0. Reset mid-run aborts the run immediately; no partial beat remains.
- States:
  - IDLE: start=1 latches mode, count and seed, and clears issued. If count==0, go to DONE. Otherwise go to RUN with beat 0 presented on the next cycle.
  - RUN: out_valid=1. A transfer occurs when out_valid && out_ready.
    - On transfer: issued++ and index++.
    - If the transfer is the last beat (issued+1==count), go to DONE; out_valid=0 on the next cycle.
    - Otherwise load the next pattern value into a/b on the next cycle (zero-bubble back-to-back).
  - DONE: done=1 and held until the next start. A start in DONE behaves as a start in IDLE.
- start while in RUN is ignored. mode, count and seed changes after start have no effect on the current run.
- Handshake:
  - a/b are stable while out_valid && !out_ready.
  - out_valid never drops without a transfer, except on reset.
  - Latency from start to first out_valid is 1 cycle.
- Pattern for beat i (index i):
  - mode 0 (sweep): a = i[WIDTH-1:0]; b = ~a. Wraps modulo 2^WIDTH.
  - mode 1 (LFSR):
    - a = LFSR state; b = a rotated left by WIDTH/2.
    - State starts at seed; seed==0 is replaced by 1.
    - Galois right-shift update on each transfer: s = (s>>1) ^ (s[0] ? TAPS : 0).
    - TAPS: WIDTH 8 → 0xB8, 16 → 0xB400, 32 → 0x80200003.
  - mode 2 (walking-one): a = 1 << (i mod WIDTH); b = a rotated left by 1.
  - mode 3 (constant): a = seed; b = ~seed for every beat.
- issued saturates at count and is held in DONE until the next start.
- Simultaneous events:
  - Reset has priority over everything.
  - A last-beat transfer takes RUN to DONE even if start is high in that cycle.

Decomposition:
- Package generate2_stim_pkg:
  - mode enum (MODE_SWEEP, MODE_LFSR, MODE_WALK, MODE_CONST)
  - state enum (IDLE, RUN, DONE)
  - function lfsr_taps(width)
  - function rotl(value, amount)
- One sub-module: generate2_stim_lfsr. Holds the WIDTH-parameterised Galois LFSR with load, enable and state output.

Test Plan:
- Sweep: WIDTH=8, mode 0, count=4, out_ready=1 → (a,b) = (00,FF), (01,FE), (02,FD), (03,FC) on 4 consecutive cycles; then done=1, issued=4.
- LFSR: mode 1, seed=0x01, count=3 → a = 01, B8, 5C and b = 10, 8B, C5. A second run with seed=0x00 yields the identical stream.
- Backpressure: mode 2, count=9; out_ready toggled 1,0,0,1,… → a/b held stable while stalled. a = 01, 02, …, 80, 01 (wrap at beat 8); exactly 9 transfers.
- count=0 with start → DONE after 1 cycle; out_valid never asserted; issued=0.
- Reset mid-run: mode 3, seed=0x5A, count=10; rst=0 after 3 transfers → next cycle out_valid=0, a=b=0, issued=0, IDLE. A new start restarts cleanly with a=5A, b=A5.
- start pulsed during RUN with a different count → ignored; the run completes with the original count.
